// File: rtl/mips_pkg.sv
// Shared multicycle MIPS controller definitions: state codes, opcode/funct values,
// ALU control codes and the per-state control word.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALUOP_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;

    localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic               iord;
        logic               alusrca;
        logic [1:0]         alusrcb;
        logic               regdst;
        logic               memtoreg;
        logic [1:0]         pcsrc;
        logic               irwrite;
        logic               regwrite;
        logic               memwrite;
        logic               pcwrite;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    // Moore control word for a state; anything not set stays 0 (ALU defaults to ADD).
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            S_DECODE:            c.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD:             c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIWB:            c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and Zero in, mux selects and enables out.
interface multicycle_control_if;
    import mips_pkg::*;

    logic [OP_W-1:0]    Op;
    logic [FUNCT_W-1:0] Funct;
    logic               Zero;
    logic [ALUC_W-1:0]  ALUControl;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               IorD;
    logic               RegDst;
    logic               MemtoReg;
    logic [1:0]         PCSrc;
    logic               IRWrite;
    logic               RegWrite;
    logic               MemWrite;
    logic               PCEn;
    logic               Illegal;
    logic [STATE_W-1:0] State;

    modport master (
        input  Op, Funct, Zero,
        output ALUControl, ALUSrcA, ALUSrcB, IorD, RegDst, MemtoReg, PCSrc,
               IRWrite, RegWrite, MemWrite, PCEn, Illegal, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  ALUControl, ALUSrcA, ALUSrcB, IorD, RegDst, MemtoReg, PCSrc,
               IRWrite, RegWrite, MemWrite, PCEn, Illegal, State
    );

endinterface

// File: rtl/alu_decoder.sv
// ALU control decode from ALUOp and Funct; flags unsupported R-type functs.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    output logic [ALUC_W-1:0]  alu_control_c_o,
    output logic               illegal_c_o
);

    always_comb begin
        alu_control_c_o = ALU_ADD;
        illegal_c_o     = 1'b0;
        case (aluop_i)
            ALUOP_SUB: alu_control_c_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_control_c_o = ALU_ADD;
                    FN_SUB:  alu_control_c_o = ALU_SUB;
                    FN_AND:  alu_control_c_o = ALU_AND;
                    FN_OR:   alu_control_c_o = ALU_OR;
                    FN_SLT:  alu_control_c_o = ALU_SLT;
                    FN_NOR:  alu_control_c_o = ALU_NOR;
                    default: illegal_c_o     = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: Moore FSM with the control word registered alongside the state.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e            state_q;
    state_e            state_d;
    ctrl_t             ctrl_q;
    logic [ALUC_W-1:0] alu_control_c;
    logic              funct_illegal_c;
    logic              op_illegal_c;

    alu_decoder u_alu_decoder (
        .funct_i         (bus.Funct),
        .aluop_i         (ctrl_q.aluop),
        .alu_control_c_o (alu_control_c),
        .illegal_c_o     (funct_illegal_c)
    );

    // Next state; Op/Funct are only consulted in DECODE, MEMADR and EXECUTE.
    always_comb begin
        state_d      = S_FETCH;
        op_illegal_c = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      op_illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.Op == OP_SW) begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = funct_illegal_c ? S_FETCH : S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    assign bus.ALUControl = alu_control_c;
    assign bus.ALUSrcA    = ctrl_q.alusrca;
    assign bus.ALUSrcB    = ctrl_q.alusrcb;
    assign bus.IorD       = ctrl_q.iord;
    assign bus.RegDst     = ctrl_q.regdst;
    assign bus.MemtoReg   = ctrl_q.memtoreg;
    assign bus.PCSrc      = ctrl_q.pcsrc;
    assign bus.State      = STATE_W'(state_q);

    // Write enables and Illegal are held low for as long as reset is high.
    assign bus.IRWrite  = ctrl_q.irwrite  & ~reset;
    assign bus.RegWrite = ctrl_q.regwrite & ~reset;
    assign bus.MemWrite = ctrl_q.memwrite & ~reset;
    assign bus.PCEn     = (ctrl_q.pcwrite | (ctrl_q.branch & bus.Zero)) & ~reset;
    assign bus.Illegal  = (op_illegal_c | funct_illegal_c) & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model checked every cycle,
// plus directed scenarios pinned against literal expectations.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] aluc;
        logic       srca;
        logic [1:0] srcb;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] pcsrc;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       pcen;
        logic       illegal;
    } exp_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];
    exp_t obs[8];
    int   obs_n;
    logic [5:0] legal_fn[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic int seq_len(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            LW:      return 5;
            SW:      return 4;
            RT:      return (funct_alu(fn) == 4'b1111) ? 3 : 4;
            BEQ:     return 3;
            ADDI:    return 4;
            JMP:     return 3;
            default: return 2;
        endcase
    endfunction

    // State visited in the idx-th cycle of an instruction.
    function automatic int seq_state(input logic [5:0] op, input int idx);
        int lw_s[5] = '{0, 1, 2, 3, 4};
        int sw_s[4] = '{0, 1, 2, 5};
        int rt_s[4] = '{0, 1, 6, 7};
        int ad_s[4] = '{0, 1, 9, 10};
        if (idx < 2) return idx;
        case (op)
            LW:      return lw_s[idx];
            SW:      return sw_s[idx];
            RT:      return rt_s[idx];
            BEQ:     return 8;
            ADDI:    return ad_s[idx];
            JMP:     return 11;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t expect_outs(input int st, input logic [5:0] op, input logic [5:0] fn,
                                         input logic z, input logic rst);
        exp_t e;
        e = '0;
        e.state = 4'(st);
        e.aluc  = 4'b0010;
        case (st)
            0:  begin e.srcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1; end
            1:  begin
                    e.srcb = 2'b11;
                    e.illegal = !(op inside {LW, SW, RT, BEQ, ADDI, JMP});
                end
            2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6:  begin
                    e.srca = 1'b1;
                    if (funct_alu(fn) == 4'b1111) e.illegal = 1'b1;
                    else e.aluc = funct_alu(fn);
                end
            7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8:  begin e.srca = 1'b1; e.aluc = 4'b0110; e.pcsrc = 2'b01; e.pcen = z; end
            9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            10: e.regwrite = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        if (rst) begin
            e.irwrite = 1'b0; e.regwrite = 1'b0; e.memwrite = 1'b0;
            e.pcen = 1'b0; e.illegal = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.state = bus.State;      a.aluc = bus.ALUControl;
        a.srca = bus.ALUSrcA;     a.srcb = bus.ALUSrcB;
        a.iord = bus.IorD;        a.regdst = bus.RegDst;
        a.memtoreg = bus.MemtoReg; a.pcsrc = bus.PCSrc;
        a.irwrite = bus.IRWrite;  a.regwrite = bus.RegWrite;
        a.memwrite = bus.MemWrite; a.pcen = bus.PCEn;
        a.illegal = bus.Illegal;
        return a;
    endfunction

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Compare process: one model expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cycle_outputs t=%0t: got %h, required %h (state %0d)", $time, a, e, e.state);
            end
        end
    end

    // Entered at posedge+1; rst_at >= 0 asserts reset for two edges starting at that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int rst_at);
        int n;
        n = seq_len(op, fn);
        obs_n = 0;
        for (int i = 0; i < n; i++) begin
            bus.Op    = op;
            bus.Funct = fn;
            bus.Zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (i == rst_at) reset = 1'b1;
            exp_q.push_back(expect_outs(seq_state(op, i), op, fn, bus.Zero, reset));
            #1;
            obs[obs_n] = sample();
            obs_n++;
            @(posedge clk); #1;
            if (i == rst_at) begin
                exp_q.push_back(expect_outs(0, op, fn, bus.Zero, 1'b1));
                #1;
                obs[obs_n] = sample();
                obs_n++;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.Op    = '0;
        bus.Funct = '0;
        bus.Zero  = 1'b0;

        // Power-up: first edge with reset puts the FSM in FETCH; outputs still gated.
        @(posedge clk); #1;
        exp_q.push_back(expect_outs(0, 6'b0, 6'b0, 1'b0, 1'b1));
        #1;
        lit("reset_state", 32'(bus.State), 0);
        lit("reset_irwrite", 32'(bus.IRWrite), 0);
        lit("reset_pcen", 32'(bus.PCEn), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(LW, 6'b0, -1, -1);
        for (int i = 0; i < 5; i++) lit($sformatf("lw_state%0d", i), 32'(obs[i].state), 32'(i));
        lit("first_fetch_irwrite", 32'(obs[0].irwrite), 1);
        lit("first_fetch_pcen", 32'(obs[0].pcen), 1);
        lit("lw_memrd_regwrite", 32'(obs[3].regwrite), 0);
        lit("lw_memwb_regwrite", 32'(obs[4].regwrite), 1);
        lit("lw_memwb_memtoreg", 32'(obs[4].memtoreg), 1);

        run_instr(RT, 6'b100111, -1, -1);
        lit("nor_aluc", 32'(obs[2].aluc), 12);
        lit("nor_wb_state", 32'(obs[3].state), 7);
        lit("nor_wb_regwrite", 32'(obs[3].regwrite), 1);
        lit("nor_wb_regdst", 32'(obs[3].regdst), 1);

        run_instr(BEQ, 6'b0, 1, -1);
        lit("beq_taken_state", 32'(obs[2].state), 8);
        lit("beq_taken_pcen", 32'(obs[2].pcen), 1);
        run_instr(BEQ, 6'b0, 0, -1);
        lit("beq_nottaken_pcen", 32'(obs[2].pcen), 0);

        run_instr(6'b111111, 6'b0, -1, -1);
        lit("illegal_op_pulse", 32'(obs[1].illegal), 1);
        lit("illegal_op_len", 32'(obs_n), 2);

        run_instr(RT, 6'b000000, -1, -1);
        lit("illegal_fn_state", 32'(obs[2].state), 6);
        lit("illegal_fn_pulse", 32'(obs[2].illegal), 1);
        lit("illegal_fn_regwrite", 32'(obs[2].regwrite), 0);
        lit("illegal_fn_len", 32'(obs_n), 3);

        run_instr(SW, 6'b0, -1, -1);
        lit("sw_memwr_memwrite", 32'(obs[3].memwrite), 1);

        run_instr(LW, 6'b0, -1, 3);
        lit("lwrst_state", 32'(obs[3].state), 3);
        lit("lwrst_regwrite", 32'(obs[3].regwrite), 0);
        lit("lwrst_memwrite", 32'(obs[3].memwrite), 0);
        lit("lwrst_next_state", 32'(obs[4].state), 0);
        lit("lwrst_next_regwrite", 32'(obs[4].regwrite), 0);

        run_instr(JMP, 6'b0, -1, -1);
        lit("jump_pcen", 32'(obs[2].pcen), 1);

        for (int k = 0; k < 300; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         ra;
            case ($urandom_range(0, 7))
                0:       op = LW;
                1:       op = SW;
                2, 3:    op = RT;
                4:       op = BEQ;
                5:       op = ADDI;
                6:       op = JMP;
                default: op = 6'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else fn = legal_fn[$urandom_range(0, 5)];
            ra = -1;
            if ($urandom_range(0, 15) == 0) ra = int'($urandom_range(0, 32'(seq_len(op, fn) - 1)));
            run_instr(op, fn, -1, ra);
        end

        @(negedge clk); #1;
        lit("model_queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Op  in  6  instruction[31:26] from instruction register.
REQ-005 Funct  in  6  instruction[5:0] from instruction register.
REQ-006 Zero  in  1  ALU Zero flag, same cycle.
REQ-007 ALUControl  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-008 ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-009 ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-010 IorD, RegDst, MemtoReg  out  1 each  standard multicycle mux selects.
REQ-011 PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-012 IRWrite, RegWrite, MemWrite, PCEn  out  1 each  datapath write enables.
REQ-013 Illegal  out  1  one-cycle pulse on unsupported Op/Funct.
REQ-014 State  out  4  current state code, for debug.

Function
REQ-015 Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH.
REQ-016 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00, IRWrite=1, PCWrite=1; next DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ADD; next by Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP; other Op -> FETCH with Illegal=1.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw -> MEMRD, sw -> MEMWR.
REQ-019 MEMRD: IorD=1 -> MEMWB; MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
REQ-020 MEMWR: IorD=1, MemWrite=1 -> FETCH.
REQ-021 EXECUTE: ALUSrcA=1, ALUSrcB=00; Funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR -> ALUWB; other Funct -> ALUControl=0010, Illegal=1, next FETCH.
REQ-022 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1 -> FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB; ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-026 PCEn = PCWrite | (Branch & Zero), combinational; Zero ignored outside BRANCH.
REQ-027 Unlisted outputs per state = 0; ALUControl = 0010 except where stated.
REQ-028 Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-029 Op/Funct sampled only in DECODE/MEMADR/EXECUTE; no other inputs affect sequencing.

Reset
REQ-030 reset high at a clk edge -> State=FETCH on that edge, overriding any transition, including mid-instruction.
REQ-031 While reset is high, PCEn, IRWrite, RegWrite, MemWrite, and Illegal are forced to 0; after reset deasserts, the first cycle is FETCH with normal outputs.

Structure
REQ-032 Shared package mips_pkg holds state codes, Op/Funct constants, and ALUControl codes; the ALU uses the same ALUControl codes.
REQ-033 Sub-module alu_decoder (Funct, ALUOp[1:0] -> ALUControl, Illegal) is the only child; the FSM is in multicycle_control.

Verification
REQ-034 reset=1 for 2 cycles then 0 -> State 0 with IRWrite=PCEn=0 during reset, then IRWrite=PCEn=1 in the first cycle after.
REQ-035 Op=100011 -> States 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in state 4; next state 0.
REQ-036 Op=000000, Funct=100111 -> ALUControl=1100 in state 6; RegWrite=1 with RegDst=1 in state 7.
REQ-037 Op=000100 with Zero=1 -> PCEn=1 in state 8; repeat with Zero=0 -> PCEn=0; both return to state 0.
REQ-038 Op=111111 -> Illegal=1 in DECODE, next state 0; Op=000000, Funct=000000 -> Illegal=1 in state 6, no RegWrite.
REQ-039 reset asserted in state 3 (lw) -> State=0 next edge, with no RegWrite or MemWrite pulse.
